// File: rtl/ysyx_24110026_alu_arb_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: one-hot ALU op codes,
// FSM state encodings and default datapath widths.
package ysyx_24110026_alu_arb_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 8;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 8'h01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 8'h02;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 8'h04;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 8'h08;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 8'h10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL = 8'h20;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL = 8'h40;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_24110026_rr_arb2.sv
// Two-input grant logic. A lone request is always granted; on a tie the
// requester that was not served last wins, unless fixed priority is selected,
// in which case requester 0 always wins.
module ysyx_24110026_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_id,
  input  logic       fixed,
  output logic [1:0] grant
);

  // One-hot grant from the current request pair
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (fixed || last_id) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24110026_alu_arb.sv
// Shares one combinational one-hot ALU between two valid/ready requesters.
// A granted request is latched in IDLE, the ALU is driven from the latched
// operands for exactly one EXEC cycle, and the captured result is offered on
// the response channel in RESP until it is taken.
// Optional build macro ALU_ARB_ONEHOT_CHECK_EN: ops that are zero or have more
// than one bit set bypass the ALU and return rsp_err=1 with zero data one
// cycle after acceptance.
module ysyx_24110026_alu_arb
  import ysyx_24110026_alu_arb_pkg::*;
#(
  parameter int DATA_W     = ALU_DATA_W,
  parameter int OP_W       = ALU_OP_W,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out
);

  state_t            state_reg, state_next;
  logic [1:0]        grant;
  logic              last_id_reg;
  logic              accept;
  logic              sel_illegal;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] a_reg, b_reg, rsp_data_reg;
  logic              id_reg;

  ysyx_24110026_rr_arb2 u_arb (
    .req     ({r1_valid, r0_valid}),
    .last_id (last_id_reg),
    .fixed   (PRIO_FIXED != 0),
    .grant   (grant)
  );

  assign accept = (state_reg == ST_IDLE) && (grant != 2'b00);
  assign sel_op = grant[1] ? r1_op : r0_op;
  assign sel_a  = grant[1] ? r1_a  : r0_a;
  assign sel_b  = grant[1] ? r1_b  : r0_b;

`ifdef ALU_ARB_ONEHOT_CHECK_EN
  logic rsp_err_reg;
  // x & (x-1) clears the lowest set bit, so it is zero only for 0 or one-hot
  assign sel_illegal = (sel_op == '0) || ((sel_op & (sel_op - OP_W'(1))) != '0);
  assign rsp_err     = rsp_err_reg;
`else
  assign sel_illegal = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign rsp_id   = id_reg;
  assign rsp_data = rsp_data_reg;

  // State register; reset abandons whatever operation is in flight
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next state, handshake outputs and ALU drive; ALU sees zeros outside EXEC
  always_comb begin
    state_next = state_reg;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    rsp_valid  = 1'b0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    case (state_reg)
      ST_IDLE: begin
        // Ready is withheld only from the loser of this cycle's grant
        r0_ready = !grant[1];
        r1_ready = !grant[0];
        if (accept) state_next = sel_illegal ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        alu_op     = op_reg;
        alu_a      = a_reg;
        alu_b      = b_reg;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, result capture and fairness history
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      id_reg       <= 1'b0;
      rsp_data_reg <= '0;
      last_id_reg  <= 1'b1;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
      rsp_err_reg  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_reg <= sel_op;
        a_reg  <= sel_a;
        b_reg  <= sel_b;
        id_reg <= grant[1];
`ifdef ALU_ARB_ONEHOT_CHECK_EN
        if (sel_illegal) begin
          rsp_data_reg <= '0;
          rsp_err_reg  <= 1'b1;
        end
`endif
      end
      if (state_reg == ST_EXEC) begin
        rsp_data_reg <= alu_out;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
        rsp_err_reg  <= 1'b0;
`endif
      end
      if (state_reg == ST_RESP && rsp_ready) last_id_reg <= id_reg;
    end
  end

endmodule

// File: tb/tb_ysyx_24110026_alu_arb.sv
// Directed bench for ysyx_24110026_alu_arb: a round-robin instance and a
// fixed-priority instance share all inputs; each has its own ALU model.
module tb_ysyx_24110026_alu_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, rsp_ready;
  logic [7:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;

  logic        r0_ready_rr, r1_ready_rr, rsp_valid_rr, rsp_id_rr, rsp_err_rr;
  logic [31:0] rsp_data_rr, alu_a_rr, alu_b_rr, alu_out_rr;
  logic [7:0]  alu_op_rr;
  logic        r0_ready_fx, r1_ready_fx, rsp_valid_fx, rsp_id_fx, rsp_err_fx;
  logic [31:0] rsp_data_fx, alu_a_fx, alu_b_fx, alu_out_fx;
  logic [7:0]  alu_op_fx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      8'h01:   return a + b;
      8'h02:   return a - b;
      8'h04:   return a ^ b;
      8'h08:   return a | b;
      8'h10:   return a & b;
      8'h20:   return a >> b[4:0];
      8'h40:   return a << b[4:0];
      8'h80:   return $signed(a) >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  assign alu_out_rr = alu_f(alu_op_rr, alu_a_rr, alu_b_rr);
  assign alu_out_fx = alu_f(alu_op_fx, alu_a_fx, alu_b_fx);

  ysyx_24110026_alu_arb #(.DATA_W(32), .OP_W(8), .PRIO_FIXED(0)) dut_rr (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready_rr), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready_rr), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid_rr), .rsp_ready(rsp_ready), .rsp_id(rsp_id_rr),
    .rsp_data(rsp_data_rr), .rsp_err(rsp_err_rr),
    .alu_op(alu_op_rr), .alu_a(alu_a_rr), .alu_b(alu_b_rr), .alu_out(alu_out_rr)
  );

  ysyx_24110026_alu_arb #(.DATA_W(32), .OP_W(8), .PRIO_FIXED(1)) dut_fx (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready_fx), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready_fx), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid_fx), .rsp_ready(rsp_ready), .rsp_id(rsp_id_fx),
    .rsp_data(rsp_data_fx), .rsp_err(rsp_err_fx),
    .alu_op(alu_op_fx), .alu_a(alu_a_fx), .alu_b(alu_b_fx), .alu_out(alu_out_fx)
  );

  typedef struct {
    logic        id;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single request through both instances, response consumed immediately
  task automatic run_txn(input logic id, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string nm);
    r0_valid = !id; r1_valid = id;
    r0_op = op; r0_a = a; r0_b = b;
    r1_op = op; r1_a = a; r1_b = b;
    rsp_ready = 1'b1;
    #1;
    chk({nm, " ready"}, id ? r1_ready_rr : r0_ready_rr, 32'd1);
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk({nm, " alu_op"}, alu_op_rr, op);
    chk({nm, " early_valid"}, rsp_valid_rr, 32'd0);
    step();
    chk({nm, " rsp_valid"}, rsp_valid_rr, 32'd1);
    chk({nm, " rsp_id"}, rsp_id_rr, id);
    chk({nm, " rsp_data"}, rsp_data_rr, exp);
    chk({nm, " rsp_data_fx"}, rsp_data_fx, exp);
    chk({nm, " rsp_err"}, rsp_err_rr, 32'd0);
    $display("[TB] txn %s id=%0d op=%h data=%h", nm, id, op, rsp_data_rr);
    step();
    chk({nm, " idle_valid"}, rsp_valid_rr, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h01, 32'd5,         32'd7,         32'd12};
    vecs[1] = '{1'b1, 8'h02, 32'd10,        32'd3,         32'd7};
    vecs[2] = '{1'b0, 8'h04, 32'h000000F0,  32'h000000FF,  32'h0000000F};
    vecs[3] = '{1'b1, 8'h08, 32'h00000F00,  32'h000000F0,  32'h00000FF0};
    vecs[4] = '{1'b0, 8'h10, 32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00};
    vecs[5] = '{1'b1, 8'h20, 32'h80000000,  32'd4,         32'h08000000};
    vecs[6] = '{1'b0, 8'h40, 32'h00000001,  32'd31,        32'h80000000};
    vecs[7] = '{1'b1, 8'h80, 32'h80000000,  32'd4,         32'hF8000000};
    vecs[8] = '{1'b0, 8'h02, 32'd3,         32'd10,        32'hFFFFFFF9};

    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    r0_op = 8'h0; r0_a = 32'h0; r0_b = 32'h0;
    r1_op = 8'h0; r1_a = 32'h0; r1_b = 32'h0;
    step(); step();
    chk("reset rsp_valid", rsp_valid_rr, 32'd0);
    chk("reset rsp_data", rsp_data_rr, 32'd0);
    chk("reset rsp_id", rsp_id_rr, 32'd0);
    chk("reset alu_op", alu_op_rr, 32'd0);
    chk("reset r0_ready", r0_ready_rr, 32'd1);
    chk("reset r1_ready", r1_ready_rr, 32'd1);
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Backpressure: response held four cycles while r1 waits
    r0_valid = 1'b1; r0_op = 8'h01; r0_a = 32'd2; r0_b = 32'd3; rsp_ready = 1'b0;
    step();
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_op = 8'h08; r1_a = 32'd1; r1_b = 32'd2;
    #1;
    chk("bp exec r1_ready", r1_ready_rr, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("bp rsp_valid", rsp_valid_rr, 32'd1);
      chk("bp rsp_data", rsp_data_rr, 32'd5);
      chk("bp rsp_id", rsp_id_rr, 32'd0);
      chk("bp r0_ready", r0_ready_rr, 32'd0);
      chk("bp r1_ready", r1_ready_rr, 32'd0);
      $display("[TB] backpressure cycle %0d valid=%0d data=%h", k, rsp_valid_rr, rsp_data_rr);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp hs valid", rsp_valid_rr, 32'd1);
    step();
    chk("bp post valid", rsp_valid_rr, 32'd0);
    chk("bp post r1_ready", r1_ready_rr, 32'd1);
    step();
    r1_valid = 1'b0;
    step();
    chk("bp r1 rsp_id", rsp_id_rr, 32'd1);
    chk("bp r1 rsp_data", rsp_data_rr, 32'd3);
    $display("[TB] txn bp_r1 id=%0d data=%h", rsp_id_rr, rsp_data_rr);
    step();

    // Reset during EXEC
    r0_valid = 1'b1; r0_op = 8'h01; r0_a = 32'd4; r0_b = 32'd4;
    step();
    r0_valid = 1'b0;
    chk("rstmid exec alu_op", alu_op_rr, 32'h01);
    rst = 1'b0;
    step();
    chk("rstmid rsp_valid", rsp_valid_rr, 32'd0);
    chk("rstmid alu_op", alu_op_rr, 32'd0);
    chk("rstmid rsp_data", rsp_data_rr, 32'd0);
    chk("rstmid r0_ready", r0_ready_rr, 32'd1);
    $display("[TB] reset mid-exec valid=%0d alu_op=%h", rsp_valid_rr, alu_op_rr);
    rst = 1'b1;

    // Contention: rr alternates starting with r0, fixed always picks r0
    r0_valid = 1'b1; r0_op = 8'h02; r0_a = 32'd10;  r0_b = 32'd3;
    r1_valid = 1'b1; r1_op = 8'h04; r1_a = 32'hF0;  r1_b = 32'hFF;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = (i % 2) == 1;
      chk("cont rr r0_ready", r0_ready_rr, !exp_id);
      chk("cont rr r1_ready", r1_ready_rr, exp_id);
      chk("cont fx r0_ready", r0_ready_fx, 32'd1);
      chk("cont fx r1_ready", r1_ready_fx, 32'd0);
      step();
      chk("cont rr alu_op", alu_op_rr, exp_id ? 32'h04 : 32'h02);
      chk("cont fx alu_op", alu_op_fx, 32'h02);
      step();
      chk("cont rr rsp_id", rsp_id_rr, exp_id);
      chk("cont rr rsp_data", rsp_data_rr, exp_id ? 32'h0F : 32'h07);
      chk("cont fx rsp_id", rsp_id_fx, 32'd0);
      chk("cont fx rsp_data", rsp_data_fx, 32'h07);
      $display("[TB] txn cont%0d rr id=%0d data=%h fx id=%0d data=%h", i, rsp_id_rr, rsp_data_rr, rsp_id_fx, rsp_data_fx);
      step();
    end
    r0_valid = 1'b0;
    #1;
    chk("fx lone r1_ready", r1_ready_fx, 32'd1);
    step(); step();
    chk("fx lone rsp_id", rsp_id_fx, 32'd1);
    chk("fx lone rsp_data", rsp_data_fx, 32'h0F);
    $display("[TB] txn fx_lone id=%0d data=%h", rsp_id_fx, rsp_data_fx);
    r1_valid = 1'b0;
    step();

    // Non-one-hot op
    r1_valid = 1'b1; r1_op = 8'h03; r1_a = 32'd1; r1_b = 32'd2;
    step();
    r1_valid = 1'b0;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
    chk("illegal rsp_valid", rsp_valid_rr, 32'd1);
    chk("illegal rsp_err", rsp_err_rr, 32'd1);
    chk("illegal rsp_data", rsp_data_rr, 32'd0);
    chk("illegal alu_op", alu_op_rr, 32'd0);
    chk("illegal rsp_id", rsp_id_rr, 32'd1);
`else
    chk("passthru alu_op", alu_op_rr, 32'h03);
    chk("passthru early_valid", rsp_valid_rr, 32'd0);
    step();
    chk("passthru rsp_valid", rsp_valid_rr, 32'd1);
    chk("passthru rsp_err", rsp_err_rr, 32'd0);
    chk("passthru rsp_data", rsp_data_rr, 32'd0);
`endif
    $display("[TB] txn op03 valid=%0d err=%0d data=%h", rsp_valid_rr, rsp_err_rr, rsp_data_rr);
    step();
    chk("op03 idle valid", rsp_valid_rr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_24110026_alu_arb.md
Name: ysyx_24110026_alu_arb

Overview:
- Sequencer/arbiter sharing the single combinational one-hot ALU between two requesters, e.g. r0 = EXU and r1 = a multi-cycle helper or CSR unit.
- Accepts a valid/ready request from each requester and grants one, round-robin by default.
- Drives the ALU from registered operands, captures the result and returns it with the requester id on a valid/ready response channel.

Parameters:
DATA_W, 32, operand/result width
OP_W, 8, one-hot ALU op width
PRIO_FIXED, 0, 0 = round-robin between r0/r1; 1 = r0 always wins

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (logic reset when rst==0 at posedge clk)
r0_valid  in  1  requester 0 request valid
r0_ready  out  1  requester 0 accepted this cycle when valid&ready
r0_op  in  OP_W  one-hot op: add 0x01, sub 0x02, xor 0x04, or 0x08, and 0x10, srl 0x20, sll 0x40, sra 0x80
r0_a  in  DATA_W  operand 1
r0_b  in  DATA_W  operand 2
r1_valid, r1_ready, r1_op, r1_a, r1_b  same as r0 for requester 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  0 = r0, 1 = r1
rsp_data  out  DATA_W  captured ALU result
rsp_err  out  1  illegal-op flag (see Optional Feature)
alu_op  out  OP_W  to ALU
alu_a  out  DATA_W  to ALU operand 1
alu_b  out  DATA_W  to ALU operand 2
alu_out  in  DATA_W  ALU result, combinational from alu_op/a/b

Behaviour:
- FSM states:
  - IDLE: r0_ready = r1_ready = 1; all other states drive both ready low.
  - EXEC: one cycle.
  - RESP: holds until handshake.
- IDLE:
  - On any accepted request, latch op, a, b and id into internal registers; next state EXEC.
  - Exactly one requester is accepted per cycle. The non-granted requester's ready is forced low in that cycle even though IDLE.
- Arbitration:
  - Only one valid: grant it.
  - Both valid with PRIO_FIXED=0: grant the id != last_id.
  - Both valid with PRIO_FIXED=1: grant r0.
- EXEC: alu_op/alu_a/alu_b = latched registers. rsp_data <= alu_out, rsp_err <= 0; next state RESP.
- Outside EXEC: alu_op = 0, alu_a = 0, alu_b = 0, so the ALU is idle and its output is 0.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - On handshake: last_id <= rsp_id; next state IDLE.
- Latency and throughput:
  - Accept at cycle N, ALU evaluated at N+1, rsp_valid high at N+2.
  - Minimum issue interval is 3 cycles (a new accept is possible at N+3 if rsp_ready was high at N+2).
- Requests not accepted must be held by the requester (standard valid/ready). The block never drops an accepted request except on reset.
- Reset (rst==0 at a posedge, in any state including mid-EXEC/RESP):
  - state <= IDLE, last_id <= 1 (r0 wins the first tie).
  - rsp_valid, rsp_id, rsp_data, rsp_err and latched registers <= 0.
  - Any in-flight operation is discarded.
- Ready outputs during reset: r*_ready derive from state and therefore read 1 in the first cycle after reset.
- Shift ops: the block does not mask operands; shift-amount interpretation belongs to the ALU.

Optional Feature:
- Macro ALU_ARB_ONEHOT_CHECK_EN.
- Defined:
  - On accept, if the op is zero or has more than one bit set, skip EXEC and go directly to RESP.
  - rsp_data = 0, rsp_err = 1; the ALU stays undriven (zeros).
  - Latency for illegal ops is 1 cycle (accept at N, rsp_valid at N+1).
- Not defined: the op is passed through unchecked; rsp_err is tied 0.

Decomposition:
- Shared package (defines file): ALU one-hot op constants (ALU_OP_ADD..ALU_OP_SRA), FSM state encodings (IDLE/EXEC/RESP, 2-bit), OP_W/DATA_W defaults.
- One natural sub-module: ysyx_24110026_rr_arb2, the 2-input round-robin grant logic (inputs req[1:0], last_id, fixed; output one-hot grant).
- The FSM and datapath registers stay in the top.

Test Plan:
- Single request: r0 add a=5 b=7, rsp_ready=1 -> r0 accepted at N, alu_op=0x01 at N+1, rsp_valid at N+2 with id=0, data=12.
- Contention and fairness: r0 and r1 both valid continuously, rsp_ready=1, PRIO_FIXED=0 -> grants alternate r0, r1, r0, r1, …
  - r0 = sub 10-3 gives data=7; r1 = xor 0xF0^0xFF gives data=0x0F.
- Backpressure: rsp_ready=0 for 4 cycles after rsp_valid -> rsp_valid/id/data held stable; r0_ready = r1_ready = 0 throughout; accept resumes the cycle after the handshake.
- Reset mid-operation: assert rst=0 during EXEC -> next cycle rsp_valid=0, alu_op=0, state IDLE.
  - After release, simultaneous r0/r1 requests -> r0 granted.
- Fixed priority: PRIO_FIXED=1, both valid for 3 transactions -> all grants go to r0; r1 is granted only when r0_valid=0.
- Macro defined, r1_op=0x03 -> rsp_valid at N+1, rsp_err=1, rsp_data=0, alu_op stays 0.
